dht_read_scheduler: RTL and testbench
=====================================

Name: dht_read_scheduler

Overview:
- Sequences a DHT-style single-wire reader core: issues start pulses, enforces the sensor's minimum inter-read gap, watchdogs each transaction, and retries on timeout or checksum failure.
- Serves periodic auto-polling plus on-demand read requests from NREQ clients.
- Publishes the last good reading to the rest of the design.
- Sits between the reader core and consumers such as the display and UART blocks.

Parameters:
- NREQ, 2: number of on-demand requesters.
- MIN_GAP_CYC, 100_000_000: minimum cycles between the end of one transaction and the next start (2 s at 50 MHz).
- TIMEOUT_CYC, 1_500_000: watchdog from rdr_start to rdr_done (30 ms).
- POLL_CYC, 250_000_000: auto-poll period, measured start-to-start.
- MAX_RETRY, 3: extra attempts after the first failure.

Ports:
- clk_50M  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- auto_en  in  1  enables periodic polling.
- req  in  NREQ  level requests, held until ack.
- ack  out  NREQ  1-cycle pulse; the request is served.
- ack_fail  out  1  qualifies ack; 1 = all attempts failed.
- rdr_start  out  1  1-cycle start pulse to the reader core.
- rdr_abort  out  1  1-cycle pulse that resets the reader core on timeout.
- rdr_done  in  1  1-cycle pulse; the frame is complete.
- rdr_data  in  40  frame: [39:32] RH_int, [31:24] RH_dec, [23:16] T_int, [15:8] T_dec, [7:0] checksum.
- T_integral, T_decimal, RH_integral, RH_decimal  out  8 each  last good reading.
- data_valid  out  1  sticky; set after the first good reading.
- busy  out  1  a transaction is in progress.
- fail_cnt  out  8  saturating count of failed attempts.

Behaviour:
- Reset (asynchronous, any state) sets every output to 0, the state to IDLE, gap_cnt to 0 and poll_cnt to 0.
  - Consequence: the first read waits the full MIN_GAP_CYC, which covers sensor power-up.
- gap_cnt counts up from 0 after each transaction end and saturates at MIN_GAP_CYC.
- poll_cnt free-runs and wraps at POLL_CYC-1, producing a poll_tick.
  - Held at 0 while auto_en=0.
  - At most one poll is pending; further ticks are dropped.
- States:
  - IDLE:
    - Leave when (|req or poll pending) and gap_cnt==MIN_GAP_CYC.
    - On leaving: snapshot req into serve_mask, clear the poll pending bit, set retry=0, go to START.
  - START: assert rdr_start for 1 cycle, clear wd_cnt, go to BUSY. busy=1 from START through PUBLISH.
  - BUSY:
    - wd_cnt increments every cycle.
    - On rdr_done, go to CHECK with rdr_data captured that cycle.
    - If wd_cnt reaches TIMEOUT_CYC-1 without rdr_done, pulse rdr_abort and go to FAIL.
    - If rdr_done and the timeout coincide, rdr_done wins.
  - CHECK:
    - Good when frame[7:0] == (sum of the four data bytes) mod 256, computed as an 8-bit wrapping add.
    - Good: go to PUBLISH. Bad: go to FAIL.
  - FAIL:
    - fail_cnt increments, saturating at 255.
    - If retry<MAX_RETRY: retry++, gap_cnt=0, go to RETRY_WAIT.
    - Otherwise go to PUBLISH with fail=1.
  - RETRY_WAIT: wait for gap_cnt==MIN_GAP_CYC, then go to START. Requests are not re-sampled.
  - PUBLISH:
    - On good: update the four outputs and set data_valid=1.
    - On fail: outputs and data_valid are unchanged.
    - Pulse ack=serve_mask with ack_fail=fail for one cycle.
    - Clear gap_cnt, go to IDLE.
- Requests:
  - A req asserted after the snapshot is served by the next transaction.
  - A req dropped mid-transaction still receives its ack; the client ignores it.
  - Requests coinciding with a poll share one transaction.
- Latencies:
  - Good read: ack arrives 2 cycles after rdr_done, with the outputs updated on the same edge as ack.
  - rdr_start is issued 1 cycle after leaving IDLE.
- A spurious rdr_done outside BUSY is ignored.

Decomposition:
- Package dht_pkg holds:
  - state enum;
  - frame byte-offset constants;
  - checksum function.
- Sub-module dht_interval_timer: saturating gap counter plus poll tick generator, instantiated once.
- The FSM, request snapshot and publish logic stay in the top module.

Test Plan:
- Bench parameters: MIN_GAP_CYC=100, TIMEOUT_CYC=50, POLL_CYC=1000.
- Good read:
  - Stimulus: req=01; the reader model returns 0x3C_05_1A_02_5D.
  - Response: rdr_start at cycle 101; ack=01, ack_fail=0; RH_integral=0x3C, T_integral=0x1A, T_decimal=0x02; data_valid=1.
- Checksum bad then good:
  - Stimulus: the first frame's checksum is 0x00, the second frame is good.
  - Response: exactly 2 rdr_start pulses ≥100 cycles apart; fail_cnt=1; ack_fail=0.
- Timeout exhaustion:
  - Stimulus: the reader never sends rdr_done.
  - Response: 4 rdr_start and 4 rdr_abort pulses; fail_cnt=4; ack_fail=1; previous outputs and data_valid retained.
- Request merge:
  - Stimulus: req[0] before start, req[1] during BUSY.
  - Response: the first ack=01, a second transaction follows, then ack=10.
- Auto-poll:
  - Stimulus: auto_en=1, no req.
  - Response: rdr_start every 1000 cycles; ack stays 0.
- Reset mid-BUSY:
  - Stimulus: reset asserted in BUSY.
  - Response: all outputs 0 immediately; the next rdr_start comes no earlier than 100 cycles after reset release.

Source files
------------

// File: rtl/dht_read_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dht_pkg : state encoding, frame layout and checksum for the DHT scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dht_pkg;

  typedef logic [2:0] state_t;

  localparam state_t C_ST_IDLE       = 3'd0;
  localparam state_t C_ST_START      = 3'd1;
  localparam state_t C_ST_BUSY       = 3'd2;
  localparam state_t C_ST_CHECK      = 3'd3;
  localparam state_t C_ST_FAIL       = 3'd4;
  localparam state_t C_ST_RETRY_WAIT = 3'd5;
  localparam state_t C_ST_PUBLISH    = 3'd6;

  localparam int unsigned C_FRAME_W    = 40;
  localparam int unsigned C_RH_INT_LSB = 32;
  localparam int unsigned C_RH_DEC_LSB = 24;
  localparam int unsigned C_T_INT_LSB  = 16;
  localparam int unsigned C_T_DEC_LSB  = 8;
  localparam int unsigned C_CSUM_LSB   = 0;

  // 8-bit wrapping sum of the four payload bytes
  function automatic logic [7:0] frame_checksum(input logic [C_FRAME_W-1:0] f);
    logic [7:0] s;
    s = f[C_RH_INT_LSB +: 8];
    s = s + f[C_RH_DEC_LSB +: 8];
    s = s + f[C_T_INT_LSB +: 8];
    s = s + f[C_T_DEC_LSB +: 8];
    return s;
  endfunction

  function automatic logic frame_good(input logic [C_FRAME_W-1:0] f);
    return f[C_CSUM_LSB +: 8] == frame_checksum(f);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dht_read_scheduler_if.sv
// ---------------------------------------------------------------------------
// dht_read_scheduler_if : client, reader-core and reading-publish signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dht_read_scheduler_if #(
  parameter int unsigned NREQ = 2
);
  logic            auto_en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic            ack_fail;
  logic            rdr_start;
  logic            rdr_abort;
  logic            rdr_done;
  logic [39:0]     rdr_data;
  logic [7:0]      T_integral;
  logic [7:0]      T_decimal;
  logic [7:0]      RH_integral;
  logic [7:0]      RH_decimal;
  logic            data_valid;
  logic            busy;
  logic [7:0]      fail_cnt;

  modport master (
    input  auto_en, req, rdr_done, rdr_data,
    output ack, ack_fail, rdr_start, rdr_abort,
           T_integral, T_decimal, RH_integral, RH_decimal,
           data_valid, busy, fail_cnt
  );

  modport slave (
    output auto_en, req, rdr_done, rdr_data,
    input  ack, ack_fail, rdr_start, rdr_abort,
           T_integral, T_decimal, RH_integral, RH_decimal,
           data_valid, busy, fail_cnt
  );
endinterface

`default_nettype wire

// File: rtl/dht_read_scheduler_interval_timer.sv
// ---------------------------------------------------------------------------
// dht_interval_timer : saturating inter-read gap counter and auto-poll tick
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dht_interval_timer #(
  parameter int unsigned MIN_GAP_CYC = 100_000_000,
  parameter int unsigned POLL_CYC    = 250_000_000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_gap_clr,
  input  wire logic i_poll_en,
  output logic      o_gap_done,
  output logic      o_poll_tick
);

  localparam int unsigned GAP_W  = (MIN_GAP_CYC > 0) ? $clog2(MIN_GAP_CYC + 1) : 1;
  localparam int unsigned POLL_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam logic [GAP_W-1:0]  C_GAP_MAX  = GAP_W'(MIN_GAP_CYC);
  localparam logic [POLL_W-1:0] C_POLL_MAX = POLL_W'(POLL_CYC - 1);

  logic [GAP_W-1:0]  r_gap_cnt;
  logic [POLL_W-1:0] r_poll_cnt;
  logic              w_poll_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt <= '0;
    end else if (i_gap_clr) begin
      r_gap_cnt <= '0;
    end else if (r_gap_cnt != C_GAP_MAX) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  assign w_poll_wrap = (r_poll_cnt == C_POLL_MAX);

  // Counter parks at zero while polling is disabled so a re-enable starts a full period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll_cnt <= '0;
    end else if (!i_poll_en || w_poll_wrap) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + POLL_W'(1);
    end
  end

  assign o_gap_done  = (r_gap_cnt == C_GAP_MAX);
  assign o_poll_tick = i_poll_en && w_poll_wrap;

endmodule

`default_nettype wire

// File: rtl/dht_read_scheduler.sv
// ---------------------------------------------------------------------------
// dht_read_scheduler : start/watchdog/retry sequencer for a DHT reader core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dht_read_scheduler
  import dht_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned MIN_GAP_CYC = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_500_000,
  parameter int unsigned POLL_CYC    = 250_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  wire logic              clk_50M,
  input  wire logic              reset,
  dht_read_scheduler_if.master   bus
);

  localparam int unsigned WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [WD_W-1:0]    C_WD_MAX    = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] C_RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t               r_state;
  logic [NREQ-1:0]      r_serve_mask;
  logic                 r_poll_pend;
  logic [RETRY_W-1:0]   r_retry;
  logic [WD_W-1:0]      r_wd_cnt;
  logic [C_FRAME_W-1:0] r_frame;
  logic                 r_rdr_start;
  logic                 r_rdr_abort;
  logic [NREQ-1:0]      r_ack;
  logic                 r_ack_fail;
  logic [7:0]           r_t_int;
  logic [7:0]           r_t_dec;
  logic [7:0]           r_rh_int;
  logic [7:0]           r_rh_dec;
  logic                 r_data_valid;
  logic [7:0]           r_fail_cnt;

  logic w_gap_done;
  logic w_poll_tick;
  logic w_gap_clr;
  logic w_leave_idle;

  assign w_gap_clr    = (r_state == C_ST_FAIL) || (r_state == C_ST_PUBLISH);
  assign w_leave_idle = (r_state == C_ST_IDLE) && ((|bus.req) || r_poll_pend) && w_gap_done;

  dht_interval_timer #(
    .MIN_GAP_CYC (MIN_GAP_CYC),
    .POLL_CYC    (POLL_CYC)
  ) u_timer (
    .clk         (clk_50M),
    .rst         (reset),
    .i_gap_clr   (w_gap_clr),
    .i_poll_en   (bus.auto_en),
    .o_gap_done  (w_gap_done),
    .o_poll_tick (w_poll_tick)
  );

  // A tick landing on the same edge as the snapshot belongs to the next period
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_poll_pend <= 1'b0;
    end else if (w_poll_tick) begin
      r_poll_pend <= 1'b1;
    end else if (w_leave_idle) begin
      r_poll_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_state      <= C_ST_IDLE;
      r_serve_mask <= '0;
      r_retry      <= '0;
      r_wd_cnt     <= '0;
      r_frame      <= '0;
      r_rdr_start  <= 1'b0;
      r_rdr_abort  <= 1'b0;
      r_ack        <= '0;
      r_ack_fail   <= 1'b0;
      r_t_int      <= '0;
      r_t_dec      <= '0;
      r_rh_int     <= '0;
      r_rh_dec     <= '0;
      r_data_valid <= 1'b0;
      r_fail_cnt   <= '0;
    end else begin
      r_rdr_start <= 1'b0;
      r_rdr_abort <= 1'b0;
      r_ack       <= '0;
      r_ack_fail  <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (w_leave_idle) begin
            r_serve_mask <= bus.req;
            r_retry      <= '0;
            r_rdr_start  <= 1'b1;
            r_state      <= C_ST_START;
          end
        end
        C_ST_START: begin
          r_wd_cnt <= '0;
          r_state  <= C_ST_BUSY;
        end
        C_ST_BUSY: begin
          if (bus.rdr_done) begin
            r_frame <= bus.rdr_data;
            r_state <= C_ST_CHECK;
          end else if (r_wd_cnt == C_WD_MAX) begin
            r_rdr_abort <= 1'b1;
            r_state     <= C_ST_FAIL;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
        end
        // Outputs and ack move together on the edge into PUBLISH
        C_ST_CHECK: begin
          if (frame_good(r_frame)) begin
            r_rh_int     <= r_frame[C_RH_INT_LSB +: 8];
            r_rh_dec     <= r_frame[C_RH_DEC_LSB +: 8];
            r_t_int      <= r_frame[C_T_INT_LSB +: 8];
            r_t_dec      <= r_frame[C_T_DEC_LSB +: 8];
            r_data_valid <= 1'b1;
            r_ack        <= r_serve_mask;
            r_state      <= C_ST_PUBLISH;
          end else begin
            r_state <= C_ST_FAIL;
          end
        end
        C_ST_FAIL: begin
          if (r_fail_cnt != 8'hFF) begin
            r_fail_cnt <= r_fail_cnt + 8'd1;
          end
          if (r_retry < C_RETRY_MAX) begin
            r_retry <= r_retry + RETRY_W'(1);
            r_state <= C_ST_RETRY_WAIT;
          end else begin
            r_ack      <= r_serve_mask;
            r_ack_fail <= 1'b1;
            r_state    <= C_ST_PUBLISH;
          end
        end
        C_ST_RETRY_WAIT: begin
          if (w_gap_done) begin
            r_rdr_start <= 1'b1;
            r_state     <= C_ST_START;
          end
        end
        C_ST_PUBLISH: begin
          r_state <= C_ST_IDLE;
        end
        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.ack_fail    = r_ack_fail;
  assign bus.rdr_start   = r_rdr_start;
  assign bus.rdr_abort   = r_rdr_abort;
  assign bus.T_integral  = r_t_int;
  assign bus.T_decimal   = r_t_dec;
  assign bus.RH_integral = r_rh_int;
  assign bus.RH_decimal  = r_rh_dec;
  assign bus.data_valid  = r_data_valid;
  assign bus.busy        = (r_state != C_ST_IDLE);
  assign bus.fail_cnt    = r_fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dht_read_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dht_read_scheduler : scoreboard bench with a scripted reader-core model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dht_read_scheduler;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned MIN_GAP = 100;
  localparam int unsigned TMO     = 50;
  localparam int unsigned POLL    = 1000;
  localparam int unsigned RETRY   = 3;
  localparam int          RDR_DLY = 5;

  typedef struct packed {
    logic [1:0] ack;
    logic       ack_fail;
    logic [7:0] rhi;
    logic [7:0] rhd;
    logic [7:0] ti;
    logic [7:0] td;
    logic       dv;
    logic [7:0] fcnt;
  } exp_t;

  typedef struct packed {
    logic        resp;
    logic [39:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dht_read_scheduler_if #(.NREQ(NREQ)) bus ();

  dht_read_scheduler #(
    .NREQ        (NREQ),
    .MIN_GAP_CYC (MIN_GAP),
    .TIMEOUT_CYC (TMO),
    .POLL_CYC    (POLL),
    .MAX_RETRY   (RETRY)
  ) dut (
    .clk_50M (clk),
    .reset   (reset),
    .bus     (bus)
  );

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   start_q[$];
  int   abort_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   n_abort = 0;
  int   n_ack = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters and scoreboard monitor
  always @(negedge clk) begin
    if (bus.rdr_start) begin
      n_start++;
      start_q.push_back(cyc);
    end
    if (bus.rdr_abort) begin
      n_abort++;
      abort_q.push_back(cyc);
    end
    if (bus.ack != '0) begin
      n_ack++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 64'(bus.ack), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack",         64'(bus.ack),         64'(mon_e.ack));
        chk("ack_fail",    64'(bus.ack_fail),    64'(mon_e.ack_fail));
        chk("RH_integral", 64'(bus.RH_integral), 64'(mon_e.rhi));
        chk("RH_decimal",  64'(bus.RH_decimal),  64'(mon_e.rhd));
        chk("T_integral",  64'(bus.T_integral),  64'(mon_e.ti));
        chk("T_decimal",   64'(bus.T_decimal),   64'(mon_e.td));
        chk("data_valid",  64'(bus.data_valid),  64'(mon_e.dv));
        chk("fail_cnt",    64'(bus.fail_cnt),    64'(mon_e.fcnt));
      end
    end
  end

  // Reader-core model: each rdr_start consumes one scripted response
  initial begin : reader
    rd_t e;
    int  cd;
    bit  pend;
    pend = 1'b0;
    cd = 0;
    e = '0;
    bus.rdr_done = 1'b0;
    bus.rdr_data = '0;
    forever begin
      @(negedge clk);
      bus.rdr_done = 1'b0;
      if (reset || bus.rdr_abort) pend = 1'b0;
      if (bus.rdr_start) begin
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          pend = e.resp;
          cd = RDR_DLY;
        end
      end else if (pend) begin
        cd--;
        if (cd == 0) begin
          bus.rdr_done = 1'b1;
          bus.rdr_data = e.data;
          pend = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int target, input int limit);
    for (int i = 0; i < limit && n_start < target; i++) tick(1);
    if (n_start < target) chk("wait_rdr_start_timeout", 64'(n_start), 64'(target));
  endtask

  task automatic wait_acks(input int target, input int limit);
    for (int i = 0; i < limit && n_ack < target; i++) tick(1);
    if (n_ack < target) chk("wait_ack_timeout", 64'(n_ack), 64'(target));
  endtask

  initial begin : watchdog
    #(40000 * 10);
    $display("FAIL watchdog: simulation exceeded its time limit (errors=%0d)", errors);
    $fatal(1);
  end

  initial begin : stim
    int rel;
    int sb;
    int ab;
    int kb;
    bus.req = '0;
    bus.auto_en = 1'b0;
    tick(3);

    chk("rst_data_valid", 64'(bus.data_valid), 64'd0);
    chk("rst_busy",       64'(bus.busy),       64'd0);
    chk("rst_rdr_start",  64'(bus.rdr_start),  64'd0);
    chk("rst_fail_cnt",   64'(bus.fail_cnt),   64'd0);
    chk("rst_T_integral", 64'(bus.T_integral), 64'd0);

    // Good read straight out of reset
    rd_q.push_back('{resp: 1'b1, data: 40'h3C_05_1A_02_5D});
    exp_q.push_back('{ack: 2'b01, ack_fail: 1'b0, rhi: 8'h3C, rhd: 8'h05,
                      ti: 8'h1A, td: 8'h02, dv: 1'b1, fcnt: 8'd0});
    bus.req = 2'b01;
    reset = 1'b0;
    rel = cyc;
    wait_starts(1, 300);
    chk("t1_start_cycle", 64'(start_q[0] - rel), 64'd101);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    wait_acks(1, 300);
    bus.req = '0;

    // Bad checksum then good frame
    sb = n_start;
    rd_q.push_back('{resp: 1'b1, data: 40'h11_22_33_44_00});
    rd_q.push_back('{resp: 1'b1, data: 40'h11_22_33_44_AA});
    exp_q.push_back('{ack: 2'b01, ack_fail: 1'b0, rhi: 8'h11, rhd: 8'h22,
                      ti: 8'h33, td: 8'h44, dv: 1'b1, fcnt: 8'd1});
    bus.req = 2'b01;
    wait_acks(2, 1000);
    bus.req = '0;
    chk("t2_start_count", 64'(n_start - sb), 64'd2);
    chk("t2_start_gap_ge_min", 64'((start_q[sb+1] - start_q[sb]) >= int'(MIN_GAP)), 64'd1);

    // Reader never answers: four attempts, all aborted
    sb = n_start;
    ab = n_abort;
    repeat (4) rd_q.push_back('{resp: 1'b0, data: 40'h0});
    exp_q.push_back('{ack: 2'b01, ack_fail: 1'b1, rhi: 8'h11, rhd: 8'h22,
                      ti: 8'h33, td: 8'h44, dv: 1'b1, fcnt: 8'd5});
    bus.req = 2'b01;
    wait_acks(3, 2000);
    bus.req = '0;
    chk("t3_start_count", 64'(n_start - sb), 64'd4);
    chk("t3_abort_count", 64'(n_abort - ab), 64'd4);
    chk("t3_start_to_abort", 64'(abort_q[ab] - start_q[sb]), 64'(TMO + 1));
    chk("t3_retry_spacing", 64'(start_q[sb+1] - start_q[sb]), 64'(TMO + 3 + MIN_GAP));

    // req[1] arrives during BUSY and gets its own transaction
    sb = n_start;
    rd_q.push_back('{resp: 1'b1, data: 40'h50_00_14_05_69});
    rd_q.push_back('{resp: 1'b1, data: 40'hFF_80_90_01_10});
    exp_q.push_back('{ack: 2'b01, ack_fail: 1'b0, rhi: 8'h50, rhd: 8'h00,
                      ti: 8'h14, td: 8'h05, dv: 1'b1, fcnt: 8'd5});
    exp_q.push_back('{ack: 2'b10, ack_fail: 1'b0, rhi: 8'hFF, rhd: 8'h80,
                      ti: 8'h90, td: 8'h01, dv: 1'b1, fcnt: 8'd5});
    bus.req = 2'b01;
    wait_starts(sb + 1, 300);
    tick(2);
    bus.req = 2'b11;
    wait_acks(4, 300);
    bus.req = 2'b10;
    wait_acks(5, 400);
    bus.req = '0;
    chk("t4_start_count", 64'(n_start - sb), 64'd2);

    // Auto-poll only: fixed start-to-start period, no acks
    sb = n_start;
    kb = n_ack;
    repeat (3) rd_q.push_back('{resp: 1'b1, data: 40'h50_00_14_05_69});
    bus.auto_en = 1'b1;
    wait_starts(sb + 3, 4000);
    bus.auto_en = 1'b0;
    tick(20);
    chk("t5_poll_period_1", 64'(start_q[sb+1] - start_q[sb]),   64'(POLL));
    chk("t5_poll_period_2", 64'(start_q[sb+2] - start_q[sb+1]), 64'(POLL));
    chk("t5_no_ack", 64'(n_ack - kb), 64'd0);

    // Asynchronous reset while BUSY
    sb = n_start;
    kb = n_ack;
    rd_q.push_back('{resp: 1'b0, data: 40'h0});
    rd_q.push_back('{resp: 1'b1, data: 40'h3C_05_1A_02_5D});
    exp_q.push_back('{ack: 2'b01, ack_fail: 1'b0, rhi: 8'h3C, rhd: 8'h05,
                      ti: 8'h1A, td: 8'h02, dv: 1'b1, fcnt: 8'd0});
    bus.req = 2'b01;
    wait_starts(sb + 1, 300);
    tick(5);
    chk("t6_busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_busy",        64'(bus.busy),        64'd0);
    chk("t6_data_valid",  64'(bus.data_valid),  64'd0);
    chk("t6_RH_integral", 64'(bus.RH_integral), 64'd0);
    chk("t6_T_decimal",   64'(bus.T_decimal),   64'd0);
    chk("t6_fail_cnt",    64'(bus.fail_cnt),    64'd0);
    tick(3);
    reset = 1'b0;
    rel = cyc;
    wait_starts(sb + 2, 300);
    chk("t6_restart_after_min_gap", 64'((start_q[sb+1] - rel) >= int'(MIN_GAP)), 64'd1);
    wait_acks(kb + 1, 300);
    bus.req = '0;
    tick(5);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
